serial_adder: RTL and testbench

Bit-serial adder that feeds one bit position per clock through the `fulladder` cell and keeps the carry in a flip-flop between bit positions. It loads two WIDTH-bit operands, adds them LSB-first over WIDTH cycles, and presents the registered sum and carry-out with a one-cycle `done` pulse. It is the sequential stage wrapped around the lab's full-adder cell: it drives the cell's `x`/`y`/`cin` and consumes its `s`/`cout`.

---
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit position per clock through a full-adder cell, carry held in a flop.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.

module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra, rb, rs;
    logic [WIDTH-1:0] rs_next;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             fa_s, fa_cout;

    fulladder u_fa (
        .x    (ra[0]),
        .y    (rb[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at rs[0].
    assign rs_next = WIDTH'({fa_s, rs} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= rs_next;
                    c   <= fa_cout;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= rs_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // c is the carry into the MSB during the last step.
                        ovf   <= c ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 instance for the main scenarios,
// WIDTH=1 instance for the full-adder truth-table sweep.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf8, ovf1;
`else
    logic ovf8 = 1'b0, ovf1 = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // {ovf, cout, sum}
    logic [9:0] q8[$];
    logic [2:0] q1[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf8),
`endif
        .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf1),
`endif
        .cout(cout1)
    );

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] r;
        logic       v;
        r = {1'b0, a} + {1'b0, b} + {8'b0, ci};
        v = (a[7] == b[7]) && (r[7] != a[7]);
        return {v, r};
    endfunction

    // Present operands with start high; returns #1 after the accepting edge with start low.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        q8.push_back(model8(a, b, ci));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Wait for done8 (bounded), counting cycles and busy samples; pops the expected entry.
    task automatic collect8(output int cyc, output int bcnt, output logic [9:0] exp, output logic got);
        cyc = 0;
        bcnt = busy8 ? 1 : 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (busy8) bcnt++;
        end while (!done8 && cyc < 40);
        got = done8;
        exp = (q8.size() > 0) ? q8.pop_front() : 10'h3ff;
    endtask

    task automatic test_reset;
        int cyc, bcnt;
        logic [9:0] e;
        logic got;
        rst_n = 1'b0; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done8); end
        n_cmp++; if ({cout8, sum8} !== 9'h000) begin n_err++; $display("FAIL reset_result got=%h exp=000", {cout8, sum8}); end
        n_cmp++; if (ovf8 !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf8); end
        rst_n = 1'b1;
        q8.push_back(model8(8'h12, 8'h34, 1'b0));
        @(posedge clk); #1;
        start8 = 1'b0;
        collect8(cyc, bcnt, e, got);
        n_cmp++; if (!got || cyc != 8) begin n_err++; $display("FAIL reset_latency got=%0d done=%b exp=8", cyc, got); end
        n_cmp++; if ({cout8, sum8} !== e[8:0]) begin n_err++; $display("FAIL reset_first_sum got=%h exp=%h", {cout8, sum8}, e[8:0]); end
    endtask

    task automatic test_add(input string nm, input logic [7:0] a, input logic [7:0] b, input logic ci,
                            input logic [8:0] req, input logic req_ovf);
        int cyc, bcnt;
        logic [9:0] e;
        logic got;
        go8(a, b, ci);
        collect8(cyc, bcnt, e, got);
        n_cmp++; if (!got || cyc != 8) begin n_err++; $display("FAIL %s_latency got=%0d exp=8", nm, cyc); end
        n_cmp++; if (bcnt != 8) begin n_err++; $display("FAIL %s_busy_cycles got=%0d exp=8", nm, bcnt); end
        n_cmp++; if ({cout8, sum8} !== req || e[8:0] !== req) begin
            n_err++; $display("FAIL %s_sum got=%h model=%h exp=%h", nm, {cout8, sum8}, e[8:0], req); end
`ifdef SERIAL_ADDER_OVF_EN
        n_cmp++; if (ovf8 !== req_ovf) begin n_err++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf8, req_ovf); end
`else
        if (req_ovf !== e[9]) $display("note: %s model ovf=%b", nm, e[9]);
`endif
        @(posedge clk); #1;
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL %s_done_width got=%b exp=0", nm, done8); end
    endtask

    task automatic test_start_in_run;
        int cyc, bcnt;
        logic [9:0] e;
        logic got;
        go8(8'hA5, 8'h3C, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        collect8(cyc, bcnt, e, got);
        n_cmp++; if (!got || cyc != 5) begin n_err++; $display("FAIL ignore_start_latency got=%0d exp=5", cyc); end
        n_cmp++; if ({cout8, sum8} !== e[8:0] || e[8:0] !== 9'h0E2) begin
            n_err++; $display("FAIL ignore_start_sum got=%h exp=%h", {cout8, sum8}, e[8:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt;
        logic [9:0] e;
        logic got;
        go8(8'h80, 8'h80, 1'b0);
        collect8(cyc, bcnt, e, got);
        n_cmp++; if ({cout8, sum8} !== e[8:0]) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", {cout8, sum8}, e[8:0]); end
        // Still in DONE: hold start so the next RUN starts on this edge.
        go8(8'h55, 8'hAA, 1'b1);
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL b2b_restart_busy got=%b exp=1", busy8); end
        n_cmp++; if ({cout8, sum8} !== e[8:0]) begin n_err++; $display("FAIL b2b_sum_hold got=%h exp=%h", {cout8, sum8}, e[8:0]); end
        collect8(cyc, bcnt, e, got);
        n_cmp++; if (!got || cyc != 8) begin n_err++; $display("FAIL b2b_latency got=%0d exp=8", cyc); end
        n_cmp++; if ({cout8, sum8} !== e[8:0] || e[8:0] !== 9'h100) begin
            n_err++; $display("FAIL b2b_second got=%h exp=%h", {cout8, sum8}, e[8:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int cyc, bcnt, seen;
        logic [9:0] e;
        logic got;
        go8(8'h11, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(q8.pop_back());
        #1;
        n_cmp++; if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            n_err++; $display("FAIL midrun_reset got=%h exp=000", {busy8, done8, cout8, sum8}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrun_no_done got=%0d active cycles exp=0", seen); end
        go8(8'hC3, 8'h4D, 1'b0);
        collect8(cyc, bcnt, e, got);
        n_cmp++; if (!got || {cout8, sum8} !== e[8:0] || e[8:0] !== 9'h110) begin
            n_err++; $display("FAIL midrun_recover got=%h done=%b exp=%h", {cout8, sum8}, got, e[8:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_width1;
        int cyc;
        logic [2:0] e;
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
            r = {1'b0, i[2]} + {1'b0, i[1]} + {1'b0, i[0]};
            q1.push_back({(i[2] == i[1]) && (r[0] != i[2]), r});
            @(posedge clk); #1;
            start1 = 1'b0;
            n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL w1_busy[%0d] got=%b exp=1", i, busy1); end
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (!done1 && cyc < 10);
            e = q1.pop_front();
            n_cmp++; if (!done1 || cyc != 1 || {cout1, sum1} !== e[1:0]) begin
                n_err++; $display("FAIL w1_add[%0d] got=%b%b cyc=%0d exp=%b", i, cout1, sum1, cyc, e[1:0]); end
`ifdef SERIAL_ADDER_OVF_EN
            n_cmp++; if (ovf1 !== e[2]) begin n_err++; $display("FAIL w1_ovf[%0d] got=%b exp=%b", i, ovf1, e[2]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_add("add0f01", 8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);
        test_add("addff01c", 8'hFF, 8'h01, 1'b1, 9'h101, 1'b0);
        test_add("add7f01", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
